// File: rtl/asip_mem_pkg.sv
// Shared definitions for the data-memory vector write path.
// Widths, beat count and the serializer state encoding.
package asip_mem_pkg;

    localparam int unsigned VEC_W     = 256;
    localparam int unsigned BEAT_W    = 64;
    localparam int unsigned NUM_BEATS = VEC_W / BEAT_W;
    localparam int unsigned ADDR_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DONE
    } vss_state_t;

    typedef logic [$clog2(NUM_BEATS)-1:0] beat_idx_t;

endpackage

// File: rtl/vector_store_serializer.sv
// Splits one VALU result into BEAT_W-wide memory writes, one beat per cycle,
// honouring a per-beat mask and a memory stall. All outputs are registered.
module vector_store_serializer #(
    parameter int unsigned VEC_W       = asip_mem_pkg::VEC_W,
    parameter int unsigned BEAT_W      = asip_mem_pkg::BEAT_W,
    parameter int unsigned ADDR_W      = asip_mem_pkg::ADDR_W,
    parameter int unsigned ADDR_STRIDE = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [VEC_W-1:0]          req_data,
    input  logic [VEC_W/BEAT_W-1:0]   req_mask,
    input  logic                      mem_stall,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [BEAT_W-1:0]         mem_vector_data,
    output logic                      mem_write_en,
    output logic                      busy,
    output logic                      done
);

    import asip_mem_pkg::*;

    localparam int unsigned BEATS = VEC_W / BEAT_W;
    localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(ADDR_STRIDE);

    vss_state_t         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [VEC_W-1:0]   data_q, data_d;
    logic [BEATS-1:0]   mask_q, mask_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [BEAT_W-1:0]  vec_d;
    logic               we_d, busy_d, done_d, ready_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            idx_q           <= '0;
            data_q          <= '0;
            mask_q          <= '0;
            mem_address     <= '0;
            mem_vector_data <= '0;
            mem_write_en    <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            req_ready       <= 1'b1;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            data_q          <= data_d;
            mask_q          <= mask_d;
            mem_address     <= addr_d;
            mem_vector_data <= vec_d;
            mem_write_en    <= we_d;
            busy            <= busy_d;
            done            <= done_d;
            req_ready       <= ready_d;
        end
    end

    // Next-cycle values of every registered output; anything not assigned holds.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        mask_d  = mask_q;
        addr_d  = mem_address;
        vec_d   = mem_vector_data;
        we_d    = mem_write_en;
        busy_d  = busy;
        ready_d = req_ready;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    data_d  = req_data;
                    mask_d  = req_mask;
                    idx_d   = '0;
                    ready_d = 1'b0;
                    if (req_mask != '0) begin
                        state_d = ST_WRITE;
                        addr_d  = req_addr;
                        vec_d   = req_data[BEAT_W-1:0];
                        we_d    = req_mask[0];
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_WRITE: begin
                // A stalled beat keeps every mem_* output frozen, masked beats included.
                if (!mem_stall) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        we_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        addr_d = mem_address + STRIDE;
                        vec_d  = data_q[idx_d*BEAT_W +: BEAT_W];
                        we_d   = mask_q[idx_d];
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
                we_d    = 1'b0;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_vector_store_serializer.sv
// Directed and randomized bench for vector_store_serializer; expected beats
// come from arithmetic on the request (base+k, data slice k, mask bit k).
module tb_vector_store_serializer;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic [255:0] req_data;
    logic [3:0]   req_mask;
    logic         mem_stall;
    logic [31:0]  mem_address;
    logic [63:0]  mem_vector_data;
    logic         mem_write_en;
    logic         busy;
    logic         done;

    int n_cmp  = 0;
    int n_fail = 0;

    vector_store_serializer #(
        .VEC_W      (256),
        .BEAT_W     (64),
        .ADDR_W     (32),
        .ADDR_STRIDE(1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_mask       (req_mask),
        .mem_stall      (mem_stall),
        .mem_address    (mem_address),
        .mem_vector_data(mem_vector_data),
        .mem_write_en   (mem_write_en),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_vec();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Caller is at a negedge with the block idle. mode: 0 no stall, 1 random stalls,
    // 2 three stall cycles while beat 1 is presented.
    task automatic run_req(input logic [31:0] addr, input logic [255:0] data,
                           input logic [3:0] mask, input int mode);
        int          k;
        int          cycles;
        int          nstall;
        int          scnt;
        logic        stall;
        logic [31:0] exp_a;
        check("ready_before_accept", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_data  = data;
        req_mask  = mask;
        mem_stall = 1'b0;
        @(negedge clk);
        // Garbage on the request port while busy must be ignored.
        req_valid = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_data  = rand_vec();
        req_mask  = 4'($urandom);
        k = 0; cycles = 1; nstall = 0; scnt = 0;
        if (mask != 4'h0) begin
            while (k < 4 && cycles < 64) begin
                exp_a = addr + 32'(k);
                check("busy", busy, 1);
                check("req_ready_busy", req_ready, 0);
                check("done_early", done, 0);
                check("mem_address", mem_address, exp_a);
                check("mem_vector_data", mem_vector_data, data[k*64 +: 64]);
                check("mem_write_en", mem_write_en, mask[k]);
                if (mode == 2) stall = (k == 1) && (scnt < 3);
                else if (mode == 1) stall = ($urandom_range(0, 2) == 0);
                else stall = 1'b0;
                mem_stall = stall;
                if (stall) begin nstall++; scnt++; end
                else k++;
                @(negedge clk);
                cycles++;
            end
        end
        check("done_latency", 64'(cycles), (mask == 4'h0) ? 64'd1 : 64'(5 + nstall));
        check("done", done, 1);
        check("busy_in_done", busy, 0);
        check("we_in_done", mem_write_en, 0);
        check("ready_in_done", req_ready, 0);
        req_valid = 1'b0;
        mem_stall = 1'($urandom_range(0, 1));
        @(negedge clk);
        mem_stall = 1'b0;
        check("done_one_cycle", done, 0);
        check("ready_after_done", req_ready, 1);
    endtask

    initial begin
        logic [255:0] d;
        logic [31:0]  a;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_mask  = '0;
        mem_stall = 1'b0;
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_we", mem_write_en, 0);
        check("rst_addr", mem_address, 0);
        check("rst_data", mem_vector_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Full store, no stall
        d = {64'h4, 64'h3, 64'h2, 64'h1};
        run_req(32'h100, d, 4'hF, 0);
        // Partial mask keeps fixed latency
        run_req(32'h100, d, 4'b0101, 0);
        // Three-cycle stall on beat 1
        run_req(32'h200, rand_vec(), 4'hF, 2);
        // Empty mask retires immediately
        run_req(32'h300, rand_vec(), 4'h0, 0);
        // Address wrap, then back-to-back request the cycle after done
        run_req(32'hFFFF_FFFE, rand_vec(), 4'hF, 0);
        run_req(32'h0000_0040, rand_vec(), 4'b1010, 0);

        // Reset in the middle of beat 2 abandons the request
        req_valid = 1'b1;
        req_addr  = 32'h500;
        req_data  = rand_vec();
        req_mask  = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_addr", mem_address, 32'h502);
        check("pre_reset_we", mem_write_en, 1);
        #2 reset = 1'b1;
        #1;
        check("midrst_we", mem_write_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", req_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_no_write", mem_write_en, 0);
            check("post_reset_no_done", done, 0);
        end
        check("post_reset_ready", req_ready, 1);

        // Randomized requests with random stalls
        for (int i = 0; i < 24; i++) begin
            a = (i % 4 == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : $urandom;
            run_req(a, rand_vec(), 4'($urandom_range(0, 15)), (i % 3 == 0) ? 0 : 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
